// File: rtl/axi4_to_sram.sv
// AXI4 slave that bridges single-outstanding bursts onto a 64-bit single-port SRAM.
// Reads use a small return buffer so that R_ready stalls never drop SRAM data.
package axi_pkg;
    localparam int ID_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [63:0]     addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
    } aw_chan_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [63:0]     addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
    } ar_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [63:0]     data;
        logic [1:0]      resp;
        logic            last;
    } r_chan_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_chan_t;
endpackage

// state | meaning
// IDLE  | waiting for AR or AW, round-robin when both are valid
// RD    | issuing SRAM reads and returning R beats
// WR    | accepting W beats, one SRAM write each
// WRESP | holding B until B_ready
module axi4_to_sram #(
    parameter int          SRAM_AW   = 10,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               AXI_AW_valid_i,
    output logic               AXI_AW_ready_o,
    input  axi_pkg::aw_chan_t  AXI_AW_bits_i,
    input  logic               AXI_AR_valid_i,
    output logic               AXI_AR_ready_o,
    input  axi_pkg::ar_chan_t  AXI_AR_bits_i,
    input  logic               AXI_W_valid_i,
    output logic               AXI_W_ready_o,
    input  axi_pkg::w_chan_t   AXI_W_bits_i,
    output logic               AXI_R_valid_o,
    input  logic               AXI_R_ready_i,
    output axi_pkg::r_chan_t   AXI_R_bits_o,
    output logic               AXI_B_valid_o,
    input  logic               AXI_B_ready_i,
    output axi_pkg::b_chan_t   AXI_B_bits_o,
    output logic               sram_req_o,
    output logic               sram_we_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [63:0]        sram_wdata_o,
    output logic [7:0]         sram_be_o,
    input  logic [63:0]        sram_rdata_i
);
    import axi_pkg::*;

    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

    state_t              state_q;
    logic                last_wr_q;
    logic [ID_W-1:0]     id_q;
    logic [63:0]         addr_q;
    logic [2:0]          size_q;
    logic                fixed_q;
    logic [7:0]          icnt_q;
    logic                idone_q;
    logic [7:0]          rcnt_q;
    logic [7:0]          wcnt_q;
    logic                err_q;
    logic                pend_q;
    logic                pend_err_q;
    logic                out_valid_q;
    logic [63:0]         out_data_q;
    logic [1:0]          out_resp_q;
    logic                skid_valid_q;
    logic [63:0]         skid_data_q;
    logic [1:0]          skid_resp_q;

    logic                idle;
    logic                ar_win;
    logic [63:0]         offset;
    logic [63:0]         beat_word;
    logic                hit;
    logic [63:0]         step;
    logic                pop;
    logic [1:0]          occ;
    logic                rd_issue;
    logic                w_hs;
    logic [63:0]         pend_data;
    logic [1:0]          pend_resp;

    assign idle   = (state_q == IDLE) && rst_i;
    assign ar_win = AXI_AR_valid_i && (!AXI_AW_valid_i || last_wr_q);
    assign AXI_AR_ready_o = idle && ar_win;
    assign AXI_AW_ready_o = idle && AXI_AW_valid_i && !ar_win;
    assign AXI_W_ready_o  = (state_q == WR);
    assign AXI_B_valid_o  = (state_q == WRESP);
    assign AXI_R_valid_o  = out_valid_q;

    assign offset    = addr_q - BASE_ADDR;
    assign beat_word = offset >> 3;
    assign hit       = (addr_q >= BASE_ADDR) && ((beat_word >> SRAM_AW) == 64'd0);
    assign step      = fixed_q ? 64'd0 : (64'd1 << size_q);

    // Reads in flight (pending) plus buffered beats may never exceed the two
    // holding registers, so a read is launched only if its data has a home.
    assign pop      = out_valid_q && AXI_R_ready_i;
    assign occ      = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, pend_q};
    assign rd_issue = (state_q == RD) && !idone_q && ((occ - {1'b0, pop}) < 2'd2);
    assign w_hs     = (state_q == WR) && AXI_W_valid_i;

    assign pend_data = pend_err_q ? 64'd0 : sram_rdata_i;
    assign pend_resp = pend_err_q ? RESP_DECERR : RESP_OKAY;

    always_comb begin
        AXI_R_bits_o      = '0;
        AXI_R_bits_o.id   = id_q;
        AXI_R_bits_o.data = out_data_q;
        AXI_R_bits_o.resp = out_resp_q;
        AXI_R_bits_o.last = out_valid_q && (rcnt_q == 8'd0);
        AXI_B_bits_o      = '0;
        AXI_B_bits_o.id   = id_q;
        AXI_B_bits_o.resp = err_q ? RESP_DECERR : RESP_OKAY;
    end

    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        if (rd_issue) begin
            sram_req_o  = hit;
            sram_addr_o = beat_word[SRAM_AW-1:0];
        end else if (w_hs) begin
            sram_req_o   = hit;
            sram_we_o    = hit;
            sram_addr_o  = beat_word[SRAM_AW-1:0];
            sram_wdata_o = AXI_W_bits_i.data;
            sram_be_o    = AXI_W_bits_i.strb;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            last_wr_q    <= 1'b1;
            id_q         <= '0;
            addr_q       <= '0;
            size_q       <= '0;
            fixed_q      <= 1'b0;
            icnt_q       <= '0;
            idone_q      <= 1'b0;
            rcnt_q       <= '0;
            wcnt_q       <= '0;
            err_q        <= 1'b0;
            pend_q       <= 1'b0;
            pend_err_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_resp_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_resp_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (AXI_AR_ready_o) begin
                        id_q      <= AXI_AR_bits_i.id;
                        addr_q    <= AXI_AR_bits_i.addr;
                        size_q    <= AXI_AR_bits_i.size;
                        fixed_q   <= (AXI_AR_bits_i.burst == BURST_FIXED);
                        icnt_q    <= AXI_AR_bits_i.len;
                        rcnt_q    <= AXI_AR_bits_i.len;
                        idone_q   <= 1'b0;
                        last_wr_q <= 1'b0;
                        state_q   <= RD;
                    end else if (AXI_AW_ready_o) begin
                        id_q      <= AXI_AW_bits_i.id;
                        addr_q    <= AXI_AW_bits_i.addr;
                        size_q    <= AXI_AW_bits_i.size;
                        fixed_q   <= (AXI_AW_bits_i.burst == BURST_FIXED);
                        wcnt_q    <= AXI_AW_bits_i.len;
                        err_q     <= 1'b0;
                        last_wr_q <= 1'b1;
                        state_q   <= WR;
                    end
                end
                RD: begin
                    if (rd_issue) begin
                        addr_q <= addr_q + step;
                        if (icnt_q == 8'd0) idone_q <= 1'b1;
                        else                icnt_q  <= icnt_q - 8'd1;
                    end
                    if (pop) begin
                        if (rcnt_q == 8'd0) state_q <= IDLE;
                        else                rcnt_q  <= rcnt_q - 8'd1;
                    end
                end
                WR: begin
                    if (w_hs) begin
                        if (!hit) err_q <= 1'b1;
                        addr_q <= addr_q + step;
                        if (AXI_W_bits_i.last || (wcnt_q == 8'd0)) state_q <= WRESP;
                        else                                         wcnt_q  <= wcnt_q - 8'd1;
                    end
                end
                WRESP: begin
                    if (AXI_B_ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            pend_q     <= rd_issue;
            pend_err_q <= rd_issue && !hit;

            // SRAM data is only valid for one cycle, so it must land somewhere.
            if (!out_valid_q || pop) begin
                if (skid_valid_q) begin
                    out_valid_q  <= 1'b1;
                    out_data_q   <= skid_data_q;
                    out_resp_q   <= skid_resp_q;
                    skid_valid_q <= pend_q;
                    if (pend_q) begin
                        skid_data_q <= pend_data;
                        skid_resp_q <= pend_resp;
                    end
                end else begin
                    out_valid_q <= pend_q;
                    if (pend_q) begin
                        out_data_q <= pend_data;
                        out_resp_q <= pend_resp;
                    end
                end
            end else if (pend_q) begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= pend_data;
                skid_resp_q  <= pend_resp;
            end
        end
    end
endmodule

// File: tb/tb_axi4_to_sram.sv
// Directed bench for axi4_to_sram with a behavioural 1-cycle-latency SRAM.
module tb_axi4_to_sram;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              aw_valid, aw_ready, ar_valid, ar_ready, w_valid, w_ready;
    logic              r_valid, r_ready, b_valid, b_ready;
    axi_pkg::aw_chan_t aw_bits;
    axi_pkg::ar_chan_t ar_bits;
    axi_pkg::w_chan_t  w_bits;
    axi_pkg::r_chan_t  r_bits;
    axi_pkg::b_chan_t  b_bits;
    logic              sram_req, sram_we;
    logic [9:0]        sram_addr;
    logic [63:0]       sram_wdata, sram_rdata;
    logic [7:0]        sram_be;

    logic [63:0] mem [0:1023];
    int          rd_log[$];
    int          wr_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    axi4_to_sram dut (
        .clk_i(clk), .rst_i(rst_n),
        .AXI_AW_valid_i(aw_valid), .AXI_AW_ready_o(aw_ready), .AXI_AW_bits_i(aw_bits),
        .AXI_AR_valid_i(ar_valid), .AXI_AR_ready_o(ar_ready), .AXI_AR_bits_i(ar_bits),
        .AXI_W_valid_i(w_valid), .AXI_W_ready_o(w_ready), .AXI_W_bits_i(w_bits),
        .AXI_R_valid_o(r_valid), .AXI_R_ready_i(r_ready), .AXI_R_bits_o(r_bits),
        .AXI_B_valid_o(b_valid), .AXI_B_ready_i(b_ready), .AXI_B_bits_o(b_bits),
        .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
    );

    function automatic logic [63:0] init_word(input int i);
        return 64'hA5A5_0000_0000_0000 | 64'(i);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < 8; b++)
                    if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
                wr_cnt <= wr_cnt + 1;
            end else begin
                sram_rdata <= mem[sram_addr];
                rd_log.push_back(int'(sram_addr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len);
        ar_bits  = '{id: id, addr: addr, len: len, size: 3'd3, burst: 2'b01};
        ar_valid = 1'b1;
    endtask

    task automatic set_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
        aw_bits  = '{id: id, addr: addr, len: len, size: 3'd3, burst: burst};
        aw_valid = 1'b1;
    endtask

    initial begin
        int n;
        int base;
        int wbase;
        logic stall_prev;
        logic [63:0] prev_data;
        logic seen;

        rst_n = 1'b1;
        aw_valid = 0; ar_valid = 0; w_valid = 0; r_ready = 0; b_ready = 0;
        aw_bits = '0; ar_bits = '0; w_bits = '0;
        #2 rst_n = 1'b0;
        ar_valid = 1; aw_valid = 1; w_valid = 1; r_ready = 1; b_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ar_ready", ar_ready, 0);
        check("rst_aw_ready", aw_ready, 0);
        check("rst_w_ready", w_ready, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_sram_req", sram_req, 0);
        check("rst_sram_we", sram_we, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_r_bits", r_bits, 0);
        check("rst_b_bits", b_bits, 0);
        ar_valid = 0; aw_valid = 0; w_valid = 0; b_ready = 0;
        rst_n = 1'b1;
        tick();

        // INCR read of words 2..5, R_ready held high
        base = rd_log.size();
        set_ar(4'd5, 64'h10, 8'd3);
        #1;
        check("t1_ar_ready", ar_ready, 1);
        check("t1_aw_ready", aw_ready, 0);
        tick();
        ar_valid = 0;
        #1;
        check("t1_req0", {sram_req, sram_we, sram_addr}, {1'b1, 1'b0, 10'd2});
        check("t1_rvalid_c1", r_valid, 0);
        tick();
        check("t1_rvalid_c2", r_valid, 0);
        check("t1_req1_addr", sram_addr, 10'd3);
        tick();
        for (int b = 0; b < 4; b++) begin
            check("t1_rvalid", r_valid, 1);
            check("t1_rdata", r_bits.data, init_word(2 + b));
            check("t1_rlast", r_bits.last, (b == 3));
            check("t1_rid_resp", {r_bits.id, r_bits.resp}, {4'd5, 2'b00});
            tick();
        end
        check("t1_rvalid_end", r_valid, 0);
        check("t1_nreads", rd_log.size() - base, 4);
        for (int i = 0; i < 4; i++) check("t1_read_addr", rd_log[base + i], 2 + i);

        // FIXED single write, partial strobe
        wbase = wr_cnt;
        set_aw(4'd9, 64'h8, 8'd0, 2'b00);
        #1;
        check("t2_aw_ready", aw_ready, 1);
        check("t2_ar_ready", ar_ready, 0);
        tick();
        aw_valid = 0;
        w_bits = '{data: 64'h1122_3344_5566_7788, strb: 8'h0F, last: 1'b1};
        w_valid = 1;
        #1;
        check("t2_w_ready", w_ready, 1);
        check("t2_sram_wr", {sram_req, sram_we, sram_addr, sram_be}, {1'b1, 1'b1, 10'd1, 8'h0F});
        check("t2_sram_wdata", sram_wdata, 64'h1122_3344_5566_7788);
        tick();
        w_valid = 0;
        check("t2_b_valid", b_valid, 1);
        check("t2_b_bits", {b_bits.id, b_bits.resp}, {4'd9, 2'b00});
        check("t2_w_ready_off", w_ready, 0);
        tick();
        check("t2_b_hold", b_valid, 1);
        b_ready = 1;
        tick();
        b_ready = 0;
        check("t2_b_done", b_valid, 0);
        check("t2_mem1", mem[1], 64'hA5A5_0000_5566_7788);
        check("t2_nwrites", wr_cnt - wbase, 1);

        // round-robin: first simultaneous grant after reset is read, next is write
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
        set_ar(4'd1, 64'h18, 8'd0);
        set_aw(4'd2, 64'h20, 8'd0, 2'b01);
        #1;
        check("t3_rr_ar_first", ar_ready, 1);
        check("t3_rr_aw_blocked", aw_ready, 0);
        tick();
        ar_valid = 0;
        #1;
        check("t3_aw_ready_in_rd", aw_ready, 0);
        tick();
        tick();
        check("t3_rdata", {r_valid, r_bits.last, r_bits.id}, {1'b1, 1'b1, 4'd1});
        check("t3_rdata_val", r_bits.data, init_word(3));
        set_ar(4'd4, 64'h0, 8'd0);
        tick();
        check("t3_rr_aw_second", aw_ready, 1);
        check("t3_rr_ar_blocked", ar_ready, 0);
        tick();
        aw_valid = 0; ar_valid = 0;
        w_bits = '{data: 64'hDEAD_BEEF_0123_4567, strb: 8'hFF, last: 1'b1};
        w_valid = 1;
        tick();
        w_valid = 0;
        b_ready = 1;
        check("t3_b", {b_valid, b_bits.id, b_bits.resp}, {1'b1, 4'd2, 2'b00});
        tick();
        b_ready = 0;
        check("t3_mem4", mem[4], 64'hDEAD_BEEF_0123_4567);

        // len=7 read with R_ready toggling
        set_ar(4'd3, 64'h40, 8'd7);
        tick();
        ar_valid = 0;
        n = 0;
        stall_prev = 0;
        prev_data = '0;
        for (int cyc = 0; cyc < 100 && n < 8; cyc++) begin
            r_ready = cyc[0];
            if (stall_prev) begin
                check("t4_stall_valid", r_valid, 1);
                check("t4_stall_data", r_bits.data, prev_data);
            end
            if (r_valid && r_ready) begin
                check("t4_rdata", r_bits.data, init_word(8 + n));
                check("t4_rlast", r_bits.last, (n == 7));
                n++;
            end
            stall_prev = r_valid && !r_ready;
            prev_data = r_bits.data;
            tick();
        end
        check("t4_beats", n, 8);
        check("t4_no_extra", r_valid, 0);
        r_ready = 1;

        // out-of-range write and read at word 1024
        wbase = wr_cnt;
        set_aw(4'd3, 64'h2000, 8'd1, 2'b01);
        tick();
        aw_valid = 0;
        w_bits = '{data: 64'h5555_5555_5555_5555, strb: 8'hFF, last: 1'b0};
        w_valid = 1;
        #1;
        check("t5_oor_req0", sram_req, 0);
        tick();
        check("t5_w_ready_b1", w_ready, 1);
        check("t5_oor_req1", sram_req, 0);
        tick();
        check("t5_extra_refused", {w_ready, sram_req}, 2'b00);
        check("t5_b_decerr", {b_valid, b_bits.id, b_bits.resp}, {1'b1, 4'd3, 2'b11});
        w_valid = 0;
        b_ready = 1;
        tick();
        b_ready = 0;
        check("t5_nwrites", wr_cnt - wbase, 0);
        set_ar(4'd6, 64'h2000, 8'd0);
        tick();
        ar_valid = 0;
        #1;
        check("t5_oor_rd_req", sram_req, 0);
        tick();
        tick();
        check("t5_r_decerr", {r_valid, r_bits.id, r_bits.resp, r_bits.last}, {1'b1, 4'd6, 2'b11, 1'b1});
        tick();

        // early W last ends a len=3 burst after one beat
        set_aw(4'd7, 64'h28, 8'd3, 2'b01);
        tick();
        aw_valid = 0;
        w_bits = '{data: 64'h0F0F_0F0F_0F0F_0F0F, strb: 8'hFF, last: 1'b1};
        w_valid = 1;
        tick();
        w_valid = 0;
        check("t5_early_last", {b_valid, w_ready, b_bits.id, b_bits.resp}, {1'b1, 1'b0, 4'd7, 2'b00});
        b_ready = 1;
        tick();
        b_ready = 0;
        check("t5_mem5", mem[5], 64'h0F0F_0F0F_0F0F_0F0F);

        // reset during beat 2 of a len=3 read
        set_ar(4'd8, 64'h10, 8'd3);
        tick();
        ar_valid = 0;
        tick();
        tick();
        tick();
        check("t6_beat2", {r_valid, r_bits.data}, {1'b1, init_word(3)});
        #2 rst_n = 0;
        #1;
        check("t6_rst_rvalid", r_valid, 0);
        check("t6_rst_req", {sram_req, sram_we}, 2'b00);
        check("t6_rst_rbits", r_bits, 0);
        check("t6_rst_b", {b_valid, w_ready, ar_ready, aw_ready}, 4'b0000);
        tick();
        tick();
        rst_n = 1;
        seen = 0;
        repeat (4) begin
            tick();
            seen = seen | r_valid | b_valid;
        end
        check("t6_no_stale_beat", seen, 0);
        set_ar(4'd10, 64'h30, 8'd1);
        tick();
        ar_valid = 0;
        tick();
        tick();
        check("t6_new_b0", {r_valid, r_bits.last, r_bits.id, r_bits.data}, {1'b1, 1'b0, 4'd10, init_word(6)});
        tick();
        check("t6_new_b1", {r_valid, r_bits.last, r_bits.resp, r_bits.data}, {1'b1, 1'b1, 2'b00, init_word(7)});
        tick();
        check("t6_done", r_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi4_to_sram.md
AXI4_TO_SRAM -- requirements
Module: axi4_to_sram

Interface
REQ-001 SHALL have parameter SRAM_AW, default 10: SRAM word-address width; depth is 2^SRAM_AW 64-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 64'h0: byte address mapped to SRAM word 0.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports AXI_AW_valid_i / AXI_AW_ready_o / AXI_AW_bits_i (axi_pkg::aw_chan_t): AXI4 write-address slave channel.
REQ-006 SHALL have ports AXI_AR_valid_i / AXI_AR_ready_o / AXI_AR_bits_i (axi_pkg::ar_chan_t): AXI4 read-address slave channel.
REQ-007 SHALL have ports AXI_W_valid_i / AXI_W_ready_o / AXI_W_bits_i (axi_pkg::w_chan_t): AXI4 write-data slave channel.
REQ-008 SHALL have ports AXI_R_valid_o / AXI_R_ready_i / AXI_R_bits_o (axi_pkg::r_chan_t): AXI4 read-data slave channel.
REQ-009 SHALL have ports AXI_B_valid_o / AXI_B_ready_i / AXI_B_bits_o (axi_pkg::b_chan_t): AXI4 write-response slave channel.
REQ-010 SHALL have port sram_req_o, output, 1 bit: SRAM access strobe.
REQ-011 SHALL have port sram_we_o, output, 1 bit: 1 = write, 0 = read.
REQ-012 SHALL have port sram_addr_o, output, SRAM_AW bits: word address.
REQ-013 SHALL have port sram_wdata_o, output, 64 bits: write data.
REQ-014 SHALL have port sram_be_o, output, 8 bits: byte enables.
REQ-015 SHALL have port sram_rdata_i, input, 64 bits: read data, valid exactly one cycle after a read request.

Function
REQ-016 SHALL implement an FSM with states IDLE, RD, WR and WRESP, and SHALL serve one transaction at a time.
REQ-017 In IDLE, a single pending AR or AW SHALL be accepted with ready=1 in the same cycle; ID, addr, len, size and burst SHALL be latched.
REQ-018 When AR and AW are valid together in IDLE, SHALL grant the channel not granted last time (round-robin); the first grant after reset SHALL go to read.
REQ-019 The beat address SHALL equal (addr - BASE_ADDR) >> 3 for the SRAM word index; INCR SHALL add (1 << size) bytes per beat; FIXED SHALL hold the address; WRAP SHALL be treated as INCR.
REQ-020 The beat counter SHALL load len and decrement per beat; the final beat SHALL occur when the counter = 0, giving len+1 beats.
REQ-021 RD SHALL issue an SRAM read per beat and place sram_rdata_i in a one-entry skid register; it SHALL issue the next read only when the skid is empty or being popped in the same cycle.
REQ-022 With R_ready held at 1, RD SHALL sustain 1 beat/cycle; the first R beat SHALL appear 2 cycles after the AR handshake.
REQ-023 R beats SHALL carry the latched ID; last SHALL be 1 only on the final beat; R_valid SHALL hold stable until R_ready.
REQ-024 WR SHALL assert W_ready=1, and each W handshake SHALL issue one SRAM write with be=strb and wdata=data.
REQ-025 WR SHALL move to WRESP on a W beat with last=1, or on the len+1-th beat, whichever comes first; extra beats are not accepted.
REQ-026 WRESP SHALL hold B_valid=1 with the latched ID until B_ready, then return to IDLE.
REQ-027 A beat whose word index is >= 2^SRAM_AW (or whose address is below BASE_ADDR) SHALL NOT access the SRAM and SHALL set resp: DECERR on that R beat, or a sticky DECERR on B; otherwise resp SHALL be OKAY.
REQ-028 Address arithmetic SHALL be 64-bit and wrap modulo 2^64; no 4 KB boundary check is performed.
REQ-029 AW_ready, AR_ready and W_ready SHALL be 0 outside IDLE, IDLE and WR respectively.

Reset
REQ-030 Asserting rst_i low SHALL, asynchronously, force IDLE, the round-robin pointer to read, and the skid to empty.
REQ-031 Under reset, all valid and ready outputs, sram_req_o and sram_we_o SHALL be 0.
REQ-032 Under reset, the data, address and resp outputs SHALL be 0.
REQ-033 A reset mid-burst SHALL abandon the transaction; no R or B beat is emitted for it afterwards.

Verification
REQ-034 AR addr=BASE+0x10, len=3, size=3, INCR, R_ready=1 -> SRAM reads at words 2,3,4,5; 4 R beats start 2 cycles after AR; last on beat 4; resp OKAY.
REQ-035 AW addr=BASE+0x8, len=0, FIXED; W strb=8'h0F, last=1 -> one SRAM write at word 1 with be=0F; then B OKAY with the AW ID.
REQ-036 AR and AW valid together after reset -> read served first; the next simultaneous request -> write served first.
REQ-037 Read len=7 with R_ready toggling 1/0 -> all 8 beats delivered in order, none dropped or duplicated; R_valid stable while stalled.
REQ-038 Write to word 2^SRAM_AW, len=1 -> no SRAM write; B resp=DECERR. Read to the same word -> R resp=DECERR.
REQ-039 rst_i low during beat 2 of a len=3 read -> all outputs 0 immediately; after release, a new read completes normally.
